parity_scheduler: RTL and testbench

Sequencer and round-robin arbiter that shares the single 8-bit parity unit of the FP ALU datapath among several requesters. It accepts whole operand words on a valid/ready port per requester and grants one at a time. It feeds the granted word byte-by-byte through the shared parity unit, then returns per-byte and whole-word parity tagged with the requester ID on a valid/ready response port.

---
 rtl/parity_scheduler_if.sv | 28 ++
 rtl/parity_scheduler.sv | 141 ++++++++++++++
 tb/tb_parity_scheduler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/parity_scheduler_if.sv
// Request/response bundle for the shared parity scheduler.
// Handshake rule for every channel: a beat transfers on a rising clk edge where
// valid & ready are both high; ready may depend combinationally on valid.
interface parity_scheduler_if #(
  parameter int NUM_REQ    = 2,
  parameter int WORD_BYTES = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ*WORD_BYTES*8-1:0] req_data;
  logic [NUM_REQ-1:0]              req_odd;
  logic                            rsp_valid;
  logic                            rsp_ready;
  logic [ID_W-1:0]                 rsp_id;
  logic [WORD_BYTES-1:0]           rsp_byte_par;
  logic                            rsp_word_par;

  modport master (
    output req_valid, req_data, req_odd, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_byte_par, rsp_word_par
  );

  modport slave (
    input  req_valid, req_data, req_odd, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_byte_par, rsp_word_par
  );
endinterface

// File: rtl/parity_scheduler.sv
// Round-robin sequencer sharing one combinational 8-bit parity unit among
// NUM_REQ requesters; each granted word is streamed through it byte by byte.
module parity_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int WORD_BYTES = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  parity_scheduler_if.slave     bus,
  output logic [7:0]            par_data,
  input  logic                  par_in,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int WW    = WORD_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [ID_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]      cnt;
  logic [WW-1:0]         word_q;
  logic                  odd_q;
  logic [ID_W-1:0]       id_q;
  logic [WORD_BYTES-1:0] byte_par_q;
  logic                  raw_q;
  logic                  word_par_q;

  logic                  gnt_found;
  logic [ID_W-1:0]       gnt_idx;
  logic [ID_W-1:0]       nxt_ptr;
  logic [NUM_REQ-1:0]    req_ready_c;
  logic                  handshake;
  logic                  last_byte;
  logic [7:0]            cur_byte;

  // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int c;
      c = int'(rr_ptr) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!gnt_found && bus.req_valid[c]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(c);
      end
    end
  end

  always_comb begin
    nxt_ptr = '0;
    if (gnt_idx != ID_W'(NUM_REQ - 1)) nxt_ptr = gnt_idx + ID_W'(1);
  end

  assign last_byte = (cnt == CNT_W'(WORD_BYTES - 1));
  assign cur_byte  = word_q[{cnt, 3'b000} +: 8];

  always_comb begin
    state_nxt   = state;
    req_ready_c = '0;
    handshake   = 1'b0;
    par_data    = 8'h00;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          req_ready_c = NUM_REQ'(1) << gnt_idx;
          handshake   = 1'b1;
          state_nxt   = RUN;
        end
      end
      RUN: begin
        par_data = cur_byte;
        if (last_byte) state_nxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Nothing may be offered or driven toward the parity unit while in reset.
    if (!rst_n) begin
      req_ready_c = '0;
      handshake   = 1'b0;
      par_data    = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      cnt        <= '0;
      word_q     <= '0;
      odd_q      <= 1'b0;
      id_q       <= '0;
      byte_par_q <= '0;
      raw_q      <= 1'b0;
      word_par_q <= 1'b0;
    end else if (handshake) begin
      word_q     <= bus.req_data[int'(gnt_idx) * WW +: WW];
      odd_q      <= bus.req_odd[gnt_idx];
      id_q       <= gnt_idx;
      rr_ptr     <= nxt_ptr;
      cnt        <= '0;
      byte_par_q <= '0;
      raw_q      <= 1'b0;
      word_par_q <= 1'b0;
    end else if (state == RUN) begin
      byte_par_q[cnt] <= par_in ^ odd_q;
      raw_q           <= raw_q ^ par_in;
      if (last_byte) begin
        cnt        <= '0;
        word_par_q <= raw_q ^ par_in ^ odd_q;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.rsp_valid    = (state == RESP) && rst_n;
  assign bus.rsp_id       = id_q;
  assign bus.rsp_byte_par = byte_par_q;
  assign bus.rsp_word_par = word_par_q;
  assign busy             = (state != IDLE) && rst_n;
  assign state_dbg        = state;

endmodule

// File: tb/tb_parity_scheduler.sv
// Directed plus randomized bench for parity_scheduler with a parity/arbitration
// reference model and an expected-response queue.
module tb_parity_scheduler;
  localparam int NUM_REQ    = 2;
  localparam int WORD_BYTES = 4;
  localparam int ID_W       = 1;
  localparam int RW         = ID_W + WORD_BYTES + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] par_data;
  logic       par_in;
  logic       busy;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;
  logic [RW-1:0] exp_q[$];

  parity_scheduler_if #(.NUM_REQ(NUM_REQ), .WORD_BYTES(WORD_BYTES)) bus();

  parity_scheduler #(.NUM_REQ(NUM_REQ), .WORD_BYTES(WORD_BYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .par_data  (par_data),
    .par_in    (par_in),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Shared parity unit: purely combinational XOR of the presented byte.
  assign par_in = ^par_data;

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int model_pick(input logic [NUM_REQ-1:0] mask);
    for (int i = 0; i < NUM_REQ; i++) begin
      int c;
      c = (m_ptr + i) % NUM_REQ;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [RW-1:0] model_rsp(input int id, input logic [31:0] w, input logic o);
    logic [WORD_BYTES-1:0] bp;
    logic                  wp;
    for (int k = 0; k < WORD_BYTES; k++) bp[k] = (^w[k*8 +: 8]) ^ o;
    wp = (^w) ^ o;
    return {ID_W'(id), bp, wp};
  endfunction

  function automatic logic [31:0] rsp_vec();
    return 32'({bus.rsp_id, bus.rsp_byte_par, bus.rsp_word_par});
  endfunction

  // One full transaction: grant, WORD_BYTES RUN cycles, response (held for
  // `hold` extra cycles with rsp_ready low), ending on the accepting edge.
  task automatic run_txn(input logic [NUM_REQ-1:0] mask, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [NUM_REQ-1:0] odd,
                         input int hold);
    int            g;
    logic [31:0]   w;
    logic [RW-1:0] e;
    @(negedge clk);
    bus.req_valid = mask;
    bus.req_data  = {d1, d0};
    bus.req_odd   = odd;
    bus.rsp_ready = (hold == 0);
    #1;
    g = model_pick(mask);
    check("grant_ready", 32'(bus.req_ready), 32'(1 << g));
    check("idle_busy", 32'(busy), 32'(0));
    w = (g == 1) ? d1 : d0;
    exp_q.push_back(model_rsp(g, w, odd[g]));
    m_ptr = (g + 1) % NUM_REQ;
    for (int k = 0; k < WORD_BYTES; k++) begin
      @(negedge clk);
      check($sformatf("par_data_b%0d", k), 32'(par_data), 32'(w[k*8 +: 8]));
      check("run_busy", 32'(busy), 32'(1));
      check("run_ready", 32'(bus.req_ready), 32'(0));
      check("run_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    end
    @(negedge clk);
    e = exp_q.pop_front();
    check("rsp_valid", 32'(bus.rsp_valid), 32'(1));
    check("rsp_fields", rsp_vec(), 32'(e));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rsp_valid", 32'(bus.rsp_valid), 32'(1));
      check("hold_fields", rsp_vec(), 32'(e));
      check("hold_ready", 32'(bus.req_ready), 32'(0));
      check("hold_busy", 32'(busy), 32'(1));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
  endtask

  task automatic idle_step();
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("idle_ready", 32'(bus.req_ready), 32'(0));
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'(0));
  endtask

  initial begin
    logic [31:0] rd;
    // reset
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.req_odd   = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_par_data", 32'(par_data), 32'(0));
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("rst_fields", rsp_vec(), 32'(0));
    rst_n         = 1'b1;
    bus.req_valid = '0;
    idle_step();

    // directed words
    run_txn(2'b01, 32'h0000_0001, 32'h1234_5678, 2'b00, 0);
    run_txn(2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 2'b10, 0);
    run_txn(2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 2'b00, 0);
    run_txn(2'b01, 32'hFF00_FF01, 32'h0000_0000, 2'b00, 0);
    idle_step();

    // both requesters valid: strict alternation, 6-cycle spacing
    for (int n = 0; n < 8; n++)
      run_txn(2'b11, $urandom, $urandom, 2'($urandom_range(0, 3)), 0);

    // response back-pressure with both requesters still asking
    run_txn(2'b11, 32'hA5A5_0F0F, 32'h8000_0001, 2'b01, 10);
    idle_step();

    // reset mid-RUN after granting requester 0
    @(negedge clk);
    rd            = $urandom;
    bus.req_valid = 2'b01;
    bus.req_data  = {32'h0, rd};
    bus.req_odd   = 2'b00;
    bus.rsp_ready = 1'b1;
    #1;
    check("pre_rst_grant", 32'(bus.req_ready), 32'(1 << model_pick(2'b01)));
    m_ptr = 1;
    @(negedge clk);
    check("pre_rst_b0", 32'(par_data), 32'(rd[7:0]));
    @(negedge clk);
    bus.req_valid = 2'b11;
    rst_n         = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_par", 32'(par_data), 32'(0));
    check("mid_rst_ready", 32'(bus.req_ready), 32'(0));
    @(negedge clk);
    rst_n         = 1'b1;
    bus.req_valid = '0;
    m_ptr         = 0;
    check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("post_rst_fields", rsp_vec(), 32'(0));
    check("post_rst_busy", 32'(busy), 32'(0));
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(bus.rsp_valid), 32'(0));
    end
    run_txn(2'b11, $urandom, $urandom, 2'b00, 0);

    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      logic [1:0] m;
      m = 2'($urandom_range(0, 3));
      if (m == 2'b00) idle_step();
      else run_txn(m, $urandom, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 2));
    end
    idle_step();

    check("exp_q_empty", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
